// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit:
// MDUOp encodings, controller state encodings and default latencies.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  localparam int unsigned MDU_MUL_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES = 10;

endpackage

// File: rtl/e_mdu_arith.sv
// Combinational multiply/divide datapath. Returns {hi, lo}:
// product for mult/multu, {remainder, quotient} for div/divu.
// Division by zero yields lo = all ones, hi = dividend.
module e_mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o
);

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;

  // Signed division is done on magnitudes so that 0x80000000 / -1 wraps
  // cleanly to 0x80000000 instead of relying on signed-overflow behaviour.
  assign a_mag = a_i[31] ? (32'd0 - a_i) : a_i;
  assign b_mag = b_i[31] ? (32'd0 - b_i) : b_i;

  // Quotient/remainder magnitudes and sign fix-up (quotient toward zero,
  // remainder follows the dividend).
  always_comb begin
    q_mag = '0;
    r_mag = '0;
    if (b_mag != 32'd0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    q_s = (a_i[31] ^ b_i[31]) ? (32'd0 - q_mag) : q_mag;
    r_s = a_i[31] ? (32'd0 - r_mag) : r_mag;
  end

  // Result selection by operation.
  always_comb begin
    res_o = '0;
    case (op_i)
      MDU_MULT:  res_o = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
      MDU_MULTU: res_o = {32'd0, a_i} * {32'd0, b_i};
      MDU_DIV: begin
        if (b_i == 32'd0) res_o = {a_i, 32'hFFFF_FFFF};
        else              res_o = {r_s, q_s};
      end
      MDU_DIVU: begin
        if (b_i == 32'd0) res_o = {a_i, 32'hFFFF_FFFF};
        else              res_o = {a_i % b_i, a_i / b_i};
      end
      default:   res_o = '0;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide controller. Owns HI/LO, sequences a fixed
// latency per operation and serves mfhi/mflo/mthi/mtlo.
// Optional build macro MDU_DIV_ZERO_GUARD_EN: div/divu by zero holds busy
// for a single cycle and leaves HI/LO untouched.
//
// state | meaning
// IDLE  | accepts start (MDUOp 1-4) and mthi/mtlo
// BUSY  | counting down; result commits to HI/LO when cnt reaches 1
module e_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MDU_MUL_CYCLES,
  parameter int unsigned DIV_CYCLES = MDU_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic [63:0] arith_res;
  logic        is_arith;
  logic        is_div;

  e_mdu_arith u_arith (
    .op_i  (MDUOp),
    .a_i   (A),
    .b_i   (B),
    .res_o (arith_res)
  );

  assign is_div   = (MDUOp == MDU_DIV) || (MDUOp == MDU_DIVU);
  assign is_arith = start && ((MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU) || is_div);

  // Next-state, counter, pending result and HI/LO write decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (is_arith) begin
          pend_hi_d = arith_res[63:32];
          pend_lo_d = arith_res[31:0];
          cnt_d     = is_div ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
          state_d   = BUSY;
`ifdef MDU_DIV_ZERO_GUARD_EN
          // Re-commit the current HI/LO after one cycle: nothing changes.
          if (is_div && (B == 32'd0)) begin
            pend_hi_d = hi_q;
            pend_lo_d = lo_q;
            cnt_d     = 4'd1;
          end
`endif
        end else if (MDUOp == MDU_MTHI) begin
          hi_d = A;
        end else if (MDUOp == MDU_MTLO) begin
          lo_d = A;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == BUSY);
  end

  // State and data registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  // Committed-register read port; pending results are never forwarded.
  always_comb begin
    MDUOut = '0;
    if (MDUOp == MDU_MFHI)      MDUOut = hi_q;
    else if (MDUOp == MDU_MFLO) MDUOut = lo_q;
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide controller for the P6 pipeline. Sits beside the E-stage ALU and sequences a multi-cycle multiply/divide resource that owns the architectural HI/LO registers. It accepts one operation per start pulse and holds busy for the operation's latency. It serves mfhi/mflo/mthi/mtlo and exposes start/busy to the hazard unit, which stalls D-stage MDU instructions.

## Interface
- MUL_CYCLES, 5: busy cycles for mult/multu.
- DIV_CYCLES, 10: busy cycles for div/divu.
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low; 0 resets on the next rising clk.
- MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9–15 act as none.
- start  input  1  one-cycle pulse; qualifies MDUOp 1–4.
- A  input  32  forwarded rs operand.
- B  input  32  forwarded rt operand.
- busy  output  1  registered; high while an operation is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- MDUOut  output  32  HI when MDUOp=5, LO when MDUOp=6, else 0. Combinational.

## Operation
- States: IDLE, BUSY. Down-counter cnt, 4 bits.
- Start in IDLE with MDUOp 1–4:
  - Compute the result from A/B in that cycle and latch it into pend_hi/pend_lo.
  - Load cnt with MUL_CYCLES or DIV_CYCLES, then go to BUSY.
- In BUSY, cnt decrements each cycle. At cnt==1, copy pend_hi/pend_lo into HI/LO and return to IDLE.
- mult/multu: {HI,LO} = full 64-bit signed or unsigned product.
- div/divu: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- mthi/mtlo in IDLE write A into HI/LO at the next edge. No start pulse is needed.
- Ignored while busy: start, mthi and mtlo. The hazard unit guarantees these never arrive; the bench checks the ignore behaviour anyway.
- mfhi/mflo return the committed HI/LO. Pending results are never forwarded.
- start with MDUOp outside 1–4 is ignored.
- Reset:
  - Clears HI, LO, pend_hi, pend_lo and cnt to 0, forces IDLE and sets busy=0.
  - Reset during BUSY aborts the operation with no commit.

## Timing
- Start sampled in cycle 0. busy=1 in cycles 1..N, where N = MUL_CYCLES or DIV_CYCLES.
- HI/LO update at the edge that ends cycle N. busy=0 in cycle N+1, and mfhi in cycle N+1 sees the new value.
- A new start is accepted in cycle N+1, giving back-to-back operations with no gap.
- Hazard unit must stall on (start | busy) for MDU-class D-stage instructions. busy alone misses cycle 0.
- mthi/mtlo: 1-cycle write latency. MDUOut: 0-cycle read.
- Reset values: busy=0, HI=0, LO=0, MDUOut=0.

## Configuration
- MDU_DIV_ZERO_GUARD_EN defined:
  - div/divu with B==0 raises busy for exactly 1 cycle.
  - HI/LO are left unchanged; nothing is committed.
- MDU_DIV_ZERO_GUARD_EN undefined:
  - B==0 runs the full DIV_CYCLES.
  - Commits LO=0xFFFFFFFF and HI=A for both signed and unsigned division.

## Structure
- Shared package mdu_pkg holds:
  - MDUOp encodings MDU_NONE … MDU_MTLO;
  - the state encodings IDLE and BUSY;
  - the default latencies.
- The controller's control-op decode shares the same MDUOp constants.
- One sub-module, e_mdu_arith: purely combinational. Takes op, A and B; returns a 64-bit {hi,lo} result.
- The e_mdu top holds the FSM, the counter and all registers.

## Test plan
- mult A=0xFFFFFFFD, B=5 → busy cycles 1–5; in cycle 6, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- multu A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE. Then mfhi in cycle 6 gives MDUOut=1.
- div A=0xFFFFFFF9, B=2 → after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu A=7, B=2 started in cycle 11 → LO=3, HI=1.
- mthi A=0x12345678, then mflo/mfhi → HI=0x12345678, LO unchanged. mtlo issued during busy → LO unchanged.
- div B=0 after mtlo 0xAA:
  - Guard defined: 1 busy cycle; LO stays 0xAA and HI is unchanged.
  - Guard undefined: 10 busy cycles; then LO=0xFFFFFFFF, HI=A.
- mult started, then reset=0 in busy cycle 3 → next cycle busy=0, HI=LO=0, and no later commit.
